// File: rtl/mux_4bit_2to1.sv
// ============================================================================
// Module      : mux_4bit_2to1
// Description : WIDTH-bit 2:1 bus selector with registered output, registered
//               select and a saturating select-toggle counter.
//               Optional feature macro: MUX_PARITY_EN (adds y_par / y_q_par).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_4bit_2to1 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             hold,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             sel_q,
  output logic [CNT_W-1:0] sel_toggle_cnt
`ifdef MUX_PARITY_EN
  ,
  output logic             y_par,
  output logic             y_q_par
`endif
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] data_q, data_d;
  logic             sel_reg_q, sel_reg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_toggle;
  logic             w_cnt_sat;

  // Pure ?: keeps X-propagation semantics on an unknown select.
  assign y = sel ? b : a;

  assign w_toggle  = (sel != sel_reg_q);
  assign w_cnt_sat = (cnt_q == c_CNT_MAX);

  always_comb begin
    data_d    = data_q;
    sel_reg_d = sel_reg_q;
    cnt_d     = cnt_q;
    if (!hold) begin
      data_d    = y;
      sel_reg_d = sel;
      if (w_toggle && !w_cnt_sat) begin
        cnt_d = cnt_q + c_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      sel_reg_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      data_q    <= data_d;
      sel_reg_q <= sel_reg_d;
      cnt_q     <= cnt_d;
    end
  end

  assign y_q            = data_q;
  assign sel_q          = sel_reg_q;
  assign sel_toggle_cnt = cnt_q;

`ifdef MUX_PARITY_EN
  logic y_par_q, y_par_d;

  assign y_par = ^y;

  always_comb begin
    y_par_d = y_par_q;
    if (!hold) begin
      y_par_d = ^y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_par_q <= 1'b0;
    end else begin
      y_par_q <= y_par_d;
    end
  end

  assign y_q_par = y_par_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_4bit_2to1.sv
// ============================================================================
// Module      : tb_mux_4bit_2to1
// Description : Randomized self-checking bench for mux_4bit_2to1 against a
//               behavioural model (optional MUX_PARITY_EN checks included).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_4bit_2to1;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a, b;
  logic             sel, hold;
  logic [WIDTH-1:0] y, y_q;
  logic             sel_q;
  logic [CNT_W-1:0] sel_toggle_cnt;
`ifdef MUX_PARITY_EN
  logic             y_par, y_q_par;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit clk_run = 1'b0;

  // Reference model state (integers, spec-level rules)
  int m_yq, m_selq, m_cnt;

  mux_4bit_2to1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .a              (a),
    .b              (b),
    .sel            (sel),
    .hold           (hold),
    .y              (y),
    .y_q            (y_q),
    .sel_q          (sel_q),
    .sel_toggle_cnt (sel_toggle_cnt)
`ifdef MUX_PARITY_EN
    ,
    .y_par          (y_par),
    .y_q_par        (y_q_par)
`endif
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_mux(input int av, input int bv, input int s);
    return s * bv + (1 - s) * av;
  endfunction

  task automatic chk_regs(input string tag);
    chk({tag, "_yq"},  32'(y_q),            32'(m_yq));
    chk({tag, "_selq"}, 32'(sel_q),         32'(m_selq));
    chk({tag, "_cnt"}, 32'(sel_toggle_cnt), 32'(m_cnt));
`ifdef MUX_PARITY_EN
    chk({tag, "_yqpar"}, 32'(y_q_par), 32'($countones(m_yq) % 2));
`endif
  endtask

  // Called just after a falling edge: drive, check y, predict, check after edge
  task automatic cycle(input int av, input int bv, input int s, input int h, input string tag);
    int ey;
    a = WIDTH'(av); b = WIDTH'(bv); sel = s[0]; hold = h[0];
    #1;
    ey = ref_mux(av, bv, s);
    chk({tag, "_y"}, 32'(y), 32'(ey));
`ifdef MUX_PARITY_EN
    chk({tag, "_ypar"}, 32'(y_par), 32'($countones(ey) % 2));
`endif
    if (h == 0) begin
      if (s != m_selq) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      m_yq   = ey;
      m_selq = s;
    end
    @(negedge clk);
    chk_regs(tag);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    m_yq = 0; m_selq = 0; m_cnt = 0;
    chk_regs("rst_async");
    @(negedge clk);
    chk_regs("rst_hold");
    rst_n = 1'b1;
  endtask

  task automatic rand_cycles(input int n, input int hold_pct);
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(15), $urandom_range(15), $urandom_range(1),
            ($urandom_range(99) < hold_pct) ? 1 : 0, "rand");
    end
  endtask

  initial begin
    a = '0; b = '0; sel = 1'b0; hold = 1'b0;

    // Combinational path with no clock running
    a = 4'b0000; b = 4'b1111; sel = 1'b0; #10;
    chk("comb1", 32'(y), 32'h0);
    sel = 1'b1; #10;
    chk("comb2", 32'(y), 32'hF);
    a = 4'b1010; b = 4'b0101; sel = 1'b0; #10;
    chk("comb3a", 32'(y), 32'hA);
    sel = 1'b1; #10;
    chk("comb3b", 32'(y), 32'h5);
`ifdef MUX_PARITY_EN
    a = 4'b1010; b = 4'b0111; sel = 1'b1; #10;
    chk("par_comb", 32'(y_par), 32'h1);
`endif

    rst_n = 1'b1;
    clk_run = 1'b1;
    @(negedge clk);
    do_reset();
    rand_cycles(40, 20);

    // Asynchronous reset mid-stream, then first-edge toggle count
    do_reset();
    cycle(4'b1010, 4'b0101, 1, 0, "t4");
    chk("t4_yq_const",  32'(y_q), 32'h5);
    chk("t4_cnt_const", 32'(sel_toggle_cnt), 32'h1);
`ifdef MUX_PARITY_EN
    cycle(4'b1010, 4'b0111, 1, 0, "t6");
    chk("t6_yqpar_const", 32'(y_q_par), 32'h1);
`endif

    // Hold freezes everything registered
    for (int i = 0; i < 3; i++) begin
      cycle($urandom_range(15), $urandom_range(15), (m_selq == 0) ? 1 : 0, 1, "hold");
    end

    // Saturation: toggle every edge
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(15), $urandom_range(15), (m_selq == 0) ? 1 : 0, 0, "sat");
    end
    chk("sat_cnt_const", 32'(sel_toggle_cnt), 32'(CNT_MAX));

    rand_cycles(150, 25);
    do_reset();
    rand_cycles(60, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
